return_address_stack: RTL and testbench
=======================================

RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default len5_config_pkg::RAS_DEPTH (8), giving the number of return-address entries (power of 2, at least 2).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush_i, input, 1 bit: synchronous clear of the whole stack (pipeline flush or exception).
REQ-005 The block SHALL have port push_i, input, 1 bit: a call (jal/jalr with rd = x1/x5) was predicted this cycle.
REQ-006 The block SHALL have port pop_i, input, 1 bit: a return (jalr with rs1 = x1/x5, rd != rs1) was predicted this cycle.
REQ-007 The block SHALL have port ret_addr_i, input, 64 bits: return address to push (call PC + 4).
REQ-008 The block SHALL have port valid_o, output, 1 bit: the stack holds at least one entry.
REQ-009 The block SHALL have port ret_addr_o, output, 64 bits: current top-of-stack address, qualified by valid_o.

Function
REQ-010 The block SHALL implement storage as a circular buffer of DEPTH x 64-bit entries, a log2(DEPTH)-bit top pointer (tos) and a log2(DEPTH)+1-bit occupancy counter (cnt) with range 0..DEPTH.
REQ-011 The block SHALL drive ret_addr_o = entry[tos] and valid_o = (cnt != 0) combinationally from registered state, with 0-cycle read latency and no input-to-output combinational path.
REQ-012 On push only, the block SHALL increment tos modulo DEPTH, write ret_addr_i into the new tos entry, and set cnt = min(cnt+1, DEPTH); the result is visible on outputs the next cycle.
REQ-013 On push only with cnt == DEPTH, the block SHALL overwrite the oldest entry (wrap-around) and leave cnt at DEPTH.
REQ-014 On pop only with cnt > 0, the block SHALL decrement tos modulo DEPTH and decrement cnt; entry contents are left unchanged.
REQ-015 On pop only with cnt == 0, the block SHALL make no state change (underflow ignored).
REQ-016 On push and pop in the same cycle (co-routine/tail-call case), the block SHALL write ret_addr_i into entry[tos] in place, leave tos unchanged, and set cnt = max(cnt, 1).
REQ-017 On flush_i, the block SHALL set tos = 0 and cnt = 0 next cycle, overriding any push or pop in the same cycle; entry contents need not be cleared.
REQ-018 The block SHALL treat ret_addr_i as don't-care when push_i is low.

Reset
REQ-019 While rst_ni is low, the block SHALL asynchronously force tos = 0, cnt = 0 and all entries = 0, so valid_o = 0 and ret_addr_o = 0.
REQ-020 On reset assertion in the middle of any push/pop sequence, the block SHALL discard all content; the first cycle after deassertion behaves as an empty stack.

Structure
REQ-021 The block SHALL take DEPTH from len5_config_pkg (RAS_DEPTH) and the 64-bit address width from the shared len5 package (XLEN); it SHALL define no new package typedefs.
REQ-022 The block SHALL be a single module with no sub-modules, with pointer and counter arithmetic inline, instantiated inside the BPU/fetch front end.

Verification
REQ-023 After reset, push 0x1000, 0x2000, then pop -> after the pushes ret_addr_o = 0x2000, valid_o = 1; after the pop ret_addr_o = 0x1000, valid_o = 1.
REQ-024 With DEPTH = 8, push 0x100..0x900 (9 pushes, step 0x100), then 9 pops -> tops are 0x900, 0x800 ... 0x200; valid_o = 0 after the 8th pop; the 9th pop leaves state unchanged.
REQ-025 Empty stack, pop_i pulsed 3 times -> valid_o stays 0, ret_addr_o stays 0; a following push of 0x40 gives top = 0x40 with valid_o = 1.
REQ-026 Push 0xA0, then push 0xB0 together with pop -> top = 0xB0, one pop then gives valid_o = 0.
REQ-027 Push 0x10, 0x20, then flush_i asserted together with push_i (0x30) -> next cycle valid_o = 0; a subsequent pop causes no change.
REQ-028 Assert rst_ni low asynchronously between clock edges while cnt = 5 -> outputs go to 0 and valid_o to 0 before the next edge; after release, a push of 0x55 gives top = 0x55 with cnt = 1.

Source files
------------

// File: rtl/len5_config_pkg.sv
// Build-time configuration knobs for the len5 core.
package len5_config_pkg;

  // Number of return-address stack entries (power of 2, at least 2).
  localparam int unsigned RAS_DEPTH = 8;

endpackage

// File: rtl/len5_pkg.sv
// Shared len5 core constants used across the front end.
package len5_pkg;

  // Architectural register / address width.
  localparam int unsigned XLEN = 64;

endpackage

// File: rtl/return_address_stack.sv
// Return address stack for the BPU/fetch front end.
// Circular buffer of return addresses. Calls push, returns pop, and a
// simultaneous call+return replaces the top in place. Overflow overwrites
// the oldest entry. Underflow is ignored. Flush empties the stack.
module return_address_stack
  import len5_pkg::*;
  import len5_config_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] ret_addr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] ret_addr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [XLEN-1:0]  entries [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [PTR_W:0]   cnt;

  logic [PTR_W-1:0] tos_nxt;
  logic [PTR_W:0]   cnt_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;

  // Outputs come straight from registered state: no input-to-output path.
  assign ret_addr_o = entries[tos];
  assign valid_o    = (cnt != '0);

  // Next pointer/counter and write target; flush overrides push and pop.
  always_comb begin
    tos_nxt = tos;
    cnt_nxt = cnt;
    wr_ptr  = tos;
    wr_en   = 1'b0;
    if (flush_i) begin
      tos_nxt = '0;
      cnt_nxt = '0;
    end else if (push_i && pop_i) begin
      // Tail call: the returning frame is replaced by the new one.
      wr_en = 1'b1;
      if (cnt == '0) begin
        cnt_nxt = (PTR_W + 1)'(1);
      end
    end else if (push_i) begin
      tos_nxt = tos + PTR_W'(1);
      wr_ptr  = tos + PTR_W'(1);
      wr_en   = 1'b1;
      // When full the pointer wrap silently overwrites the oldest entry.
      if (cnt != CNT_FULL) begin
        cnt_nxt = cnt + (PTR_W + 1)'(1);
      end
    end else if (pop_i && (cnt != '0)) begin
      tos_nxt = tos - PTR_W'(1);
      cnt_nxt = cnt - (PTR_W + 1)'(1);
    end
  end

  // Top pointer and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos <= '0;
      cnt <= '0;
    end else begin
      tos <= tos_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Entry storage; cleared on reset so an empty stack reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_ptr] <= ret_addr_i;
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Testbench for return_address_stack: directed scenarios plus a randomized
// run checked against a bounded-queue model of a return stack.
module tb_return_address_stack;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        push_i;
  logic        pop_i;
  logic [63:0] ret_addr_i;
  logic        valid_o;
  logic [63:0] ret_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue of live return addresses, newest at the back.
  logic [63:0] model_q[$];

  return_address_stack #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push_i    (push_i),
    .pop_i     (pop_i),
    .ret_addr_i(ret_addr_i),
    .valid_o   (valid_o),
    .ret_addr_o(ret_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, {63'd0, valid_o}, {63'd0, (model_q.size() != 0)});
    if (model_q.size() != 0) begin
      check({tag, ".top"}, ret_addr_o, model_q[$]);
    end
  endtask

  task automatic model_update(input logic push, input logic pop, input logic flush,
                              input logic [63:0] addr);
    if (flush) begin
      model_q.delete();
    end else if (push && pop) begin
      if (model_q.size() == 0) model_q.push_back(addr);
      else model_q[model_q.size() - 1] = addr;
    end else if (push) begin
      model_q.push_back(addr);
      if (model_q.size() > DEPTH) void'(model_q.pop_front());
    end else if (pop) begin
      if (model_q.size() != 0) void'(model_q.pop_back());
    end
  endtask

  // One clock cycle with the given controls, then inputs return to idle.
  task automatic step(input logic push, input logic pop, input logic flush,
                      input logic [63:0] addr, input string tag);
    push_i     = push;
    pop_i      = pop;
    flush_i    = flush;
    ret_addr_i = addr;
    @(posedge clk_i);
    model_update(push, pop, flush, addr);
    #1;
    push_i     = 1'b0;
    pop_i      = 1'b0;
    flush_i    = 1'b0;
    ret_addr_i = '0;
    check_model(tag);
  endtask

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    push_i     = 1'b0;
    pop_i      = 1'b0;
    ret_addr_i = '0;
    #12;
    check("reset.valid", {63'd0, valid_o}, 64'd0);
    check("reset.addr", ret_addr_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Underflow on a freshly reset stack.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0, "underflow");
      check("underflow.valid", {63'd0, valid_o}, 64'd0);
      check("underflow.addr", ret_addr_o, 64'd0);
    end
    step(1'b1, 1'b0, 1'b0, 64'h40, "push40");
    check("push40.top", ret_addr_o, 64'h40);
    step(1'b0, 1'b0, 1'b1, 64'h0, "flush0");

    // Basic push/push/pop.
    step(1'b1, 1'b0, 1'b0, 64'h1000, "basic.p1");
    step(1'b1, 1'b0, 1'b0, 64'h2000, "basic.p2");
    check("basic.top2", ret_addr_o, 64'h2000);
    check("basic.valid2", {63'd0, valid_o}, 64'd1);
    step(1'b0, 1'b1, 1'b0, 64'h0, "basic.pop");
    check("basic.top1", ret_addr_o, 64'h1000);
    check("basic.valid1", {63'd0, valid_o}, 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'h0, "flush1");

    // Overflow by one, then drain past empty.
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 1'b0, 64'(i * 'h100), "ovf.push");
    end
    check("ovf.top", ret_addr_o, 64'h900);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0, "ovf.pop");
      if (k <= 7) check("ovf.popped_top", ret_addr_o, 64'(64'h900 - k * 'h100));
      else check("ovf.empty", {63'd0, valid_o}, 64'd0);
    end
    // Pointer wrapped back to the slot holding 0x900; underflow must not move it.
    check("ovf.stale_top", ret_addr_o, 64'h900);
    step(1'b0, 1'b0, 1'b1, 64'h0, "flush2");

    // Push together with pop replaces the top.
    step(1'b1, 1'b0, 1'b0, 64'hA0, "tail.p");
    step(1'b1, 1'b1, 1'b0, 64'hB0, "tail.pp");
    check("tail.top", ret_addr_o, 64'hB0);
    step(1'b0, 1'b1, 1'b0, 64'h0, "tail.pop");
    check("tail.empty", {63'd0, valid_o}, 64'd0);

    // Flush wins over a simultaneous push.
    step(1'b1, 1'b0, 1'b0, 64'h10, "fl.p1");
    step(1'b1, 1'b0, 1'b0, 64'h20, "fl.p2");
    step(1'b1, 1'b0, 1'b1, 64'h30, "fl.flushpush");
    check("fl.valid", {63'd0, valid_o}, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'h0, "fl.pop");
    check("fl.pop_valid", {63'd0, valid_o}, 64'd0);

    // Asynchronous reset between edges with five entries held.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 64'(64'h700 + i), "ar.push");
    end
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("ar.valid", {63'd0, valid_o}, 64'd0);
    check("ar.addr", ret_addr_o, 64'd0);
    model_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0, 64'h55, "ar.push55");
    check("ar.top55", ret_addr_o, 64'h55);
    step(1'b0, 1'b1, 1'b0, 64'h0, "ar.pop55");
    check("ar.one_entry", {63'd0, valid_o}, 64'd0);

    // Randomized: push-heavy, pop-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 600; n++) begin
        int unsigned r;
        logic p, q, f;
        r = $urandom_range(0, 99);
        f = (r < 2);
        case (ph)
          0: begin p = ($urandom_range(0, 99) < 70); q = ($urandom_range(0, 99) < 25); end
          1: begin p = ($urandom_range(0, 99) < 25); q = ($urandom_range(0, 99) < 70); end
          default: begin p = ($urandom_range(0, 99) < 50); q = ($urandom_range(0, 99) < 50); end
        endcase
        step(p, q, f, {$urandom, $urandom}, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
